// File: rtl/joy_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the DB15 serial joystick link (reader and device side).
package joy_pkg;

  // Default buttons per player; the host reader uses the same value.
  localparam int JOY_WIDTH = 16;

  // Button bit positions inside a player vector (active high at the core side).
  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_FIRE1 = 4;
  localparam int BTN_FIRE2 = 5;
  localparam int BTN_FIRE3 = 6;
  localparam int BTN_FIRE4 = 7;
  localparam int BTN_FIRE5 = 8;
  localparam int BTN_FIRE6 = 9;
  localparam int BTN_MENU  = 10;

  // Link-side state of the emulated shift chain.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    SHIFT   = 2'd2
  } link_state_t;

endpackage

// File: rtl/joy_sync_edge.sv
`timescale 1ns/1ps
// Multi-stage synchronizer for one asynchronous input with a reset preset
// value, plus a history flop that turns level changes into one-cycle pulses.
// STAGES must be at least 2.
module joy_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic PRESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the pin through the synchronizer chain and remember the previous synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{PRESET}};
      hist_q <= PRESET;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~hist_q;
  assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/joy_db15_tx.sv
`timescale 1ns/1ps
// Device side of the DB15 joystick link: behaves like two cascaded 74HC165
// style parallel-in/serial-out chains. While LOAD is low the chain follows the
// buttons; after LOAD releases, each rising link clock presents the next bit
// (active low, player 1 bit 0 first). A frame ends after 2*WIDTH shifts.
module joy_db15_tx
  import joy_pkg::*;
#(
  parameter int WIDTH       = JOY_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             I_RESET_L,
  input  logic [WIDTH-1:0] I_JOY1,
  input  logic [WIDTH-1:0] I_JOY2,
  input  logic             I_JOY_LOAD,
  input  logic             I_JOY_CLK,
  output logic             O_JOY_DATA,
  output logic             O_FRAME_DONE,
  output logic [7:0]       O_FRAME_CNT
);

  localparam int CHAIN = 2 * WIDTH;
  localparam int IDX_W = $clog2(CHAIN) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN);

  logic load_level;
  logic load_rise_unused;
  logic load_fall_unused;
  logic link_clk_level_unused;
  logic link_clk_rise;
  logic link_clk_fall_unused;

  link_state_t      state_q, state_d;
  logic [CHAIN-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             data_d;
  logic             done_d;
  logic [7:0]       cnt_q, cnt_d;

  joy_sync_edge #(
    .STAGES (SYNC_STAGES),
    .PRESET (1'b1)
  ) u_sync_load (
    .clk   (CLK),
    .rst_n (I_RESET_L),
    .din   (I_JOY_LOAD),
    .level (load_level),
    .rise  (load_rise_unused),
    .fall  (load_fall_unused)
  );

  joy_sync_edge #(
    .STAGES (SYNC_STAGES),
    .PRESET (1'b1)
  ) u_sync_clk (
    .clk   (CLK),
    .rst_n (I_RESET_L),
    .din   (I_JOY_CLK),
    .level (link_clk_level_unused),
    .rise  (link_clk_rise),
    .fall  (link_clk_fall_unused)
  );

  // State, chain, index and the registered link outputs.
  always_ff @(posedge CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q      <= IDLE;
      shift_q      <= '1;
      idx_q        <= '0;
      O_JOY_DATA   <= 1'b1;
      O_FRAME_DONE <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      O_JOY_DATA   <= data_d;
      O_FRAME_DONE <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: a low LOAD always wins (transparent reload, link edges ignored);
  // otherwise rising link edges shift ones in from the tail.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    if (!load_level) begin
      state_d = LOADING;
      shift_d = {~I_JOY2, ~I_JOY1};
      idx_d   = '0;
    end else begin
      case (state_q)
        LOADING: begin
          state_d = SHIFT;
        end
        SHIFT: begin
          if (link_clk_rise) begin
            shift_d = {1'b1, shift_q[CHAIN-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_d == LAST_IDX) begin
              done_d  = 1'b1;
              cnt_d   = cnt_q + 8'd1;
              state_d = IDLE;
            end
          end
        end
        IDLE: begin
          if (link_clk_rise) begin
            shift_d = {1'b1, shift_q[CHAIN-1:1]};
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    data_d = shift_d[0];
  end

  assign O_FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
`timescale 1ns/1ps
// Bench for joy_db15_tx: drives the link like a host reader, queues the
// expected serial bit for every link clock, and a monitor compares the data
// line at each rising link edge against the queue.
module tb_joy_db15_tx;

  localparam int WIDTH = 16;

  logic             CLK = 1'b0;
  logic             I_RESET_L;
  logic [WIDTH-1:0] I_JOY1;
  logic [WIDTH-1:0] I_JOY2;
  logic             I_JOY_LOAD;
  logic             I_JOY_CLK;
  logic             O_JOY_DATA;
  logic             O_FRAME_DONE;
  logic [7:0]       O_FRAME_CNT;

  typedef struct {
    bit do_check;
    bit exp_bit;
    int idx;
  } sb_item_t;

  sb_item_t sb_queue[$];
  int  tests_run    = 0;
  int  tests_failed = 0;
  int  done_count   = 0;
  int  exp_frames   = 0;
  int  done_before  = 0;
  bit  mon_enable   = 1'b0;

  joy_db15_tx #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .CLK          (CLK),
    .I_RESET_L    (I_RESET_L),
    .I_JOY1       (I_JOY1),
    .I_JOY2       (I_JOY2),
    .I_JOY_LOAD   (I_JOY_LOAD),
    .I_JOY_CLK    (I_JOY_CLK),
    .O_JOY_DATA   (O_JOY_DATA),
    .O_FRAME_DONE (O_FRAME_DONE),
    .O_FRAME_CNT  (O_FRAME_CNT)
  );

  // 50 MHz system clock.
  always #10 CLK = ~CLK;

  // Scoreboard monitor: the reader samples DATA just before each rising link edge.
  always @(posedge I_JOY_CLK) begin
    sb_item_t item;
    if (mon_enable) begin
      if (sb_queue.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL sb_underflow: link edge with no expected bit queued");
      end else begin
        item = sb_queue.pop_front();
        if (item.do_check) begin
          tests_run++;
          if (O_JOY_DATA !== item.exp_bit) begin
            tests_failed++;
            $display("[TB] FAIL data_bit_%0d: got %b, expected %b", item.idx, O_JOY_DATA, item.exp_bit);
          end
        end
      end
    end
  end

  // Count frame-done pulses, sampled on the inactive clock edge.
  always @(negedge CLK) begin
    if (O_FRAME_DONE === 1'b1) done_count++;
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit chain_bit(input logic [WIDTH-1:0] j1, input logic [WIDTH-1:0] j2, input int i);
    if (i < WIDTH) return ~j1[i];
    else if (i < 2 * WIDTH) return ~j2[i - WIDTH];
    else return 1'b1;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic link_pulse(input int hp, input bit do_check, input bit exp_bit, input int idx);
    I_JOY_CLK = 1'b0;
    #hp;
    sb_queue.push_back('{do_check: do_check, exp_bit: exp_bit, idx: idx});
    I_JOY_CLK = 1'b1;
    #hp;
  endtask

  task automatic load_snapshot(input logic [WIDTH-1:0] j1, input logic [WIDTH-1:0] j2,
                               input int low_time, input int settle);
    I_JOY1     = j1;
    I_JOY2     = j2;
    I_JOY_LOAD = 1'b0;
    #low_time;
    I_JOY_LOAD = 1'b1;
    #settle;
  endtask

  task automatic shift_bits(input logic [WIDTH-1:0] j1, input logic [WIDTH-1:0] j2,
                            input int first, input int count, input int hp, input bit do_check);
    for (int i = first; i < first + count; i++) begin
      link_pulse(hp, do_check, chain_bit(j1, j2, i), i);
    end
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] j1, input logic [WIDTH-1:0] j2,
                                input int n_bits, input int hp, input bit do_check);
    if (hp >= 500) load_snapshot(j1, j2, 1000, 500);
    else load_snapshot(j1, j2, 100, 100);
    shift_bits(j1, j2, 0, n_bits, hp, do_check);
  endtask

  initial begin
    I_RESET_L  = 1'b0;
    I_JOY_LOAD = 1'b1;
    I_JOY_CLK  = 1'b1;
    I_JOY1     = 16'h0001;
    I_JOY2     = 16'h0000;
    #3;
    #100;
    check_output("reset_data", O_JOY_DATA, 1);
    check_output("reset_done", O_FRAME_DONE, 0);
    check_output("reset_cnt", O_FRAME_CNT, 0);
    I_RESET_L = 1'b1;
    #200;
    check_output("idle_data", O_JOY_DATA, 1);
    check_output("idle_cnt", O_FRAME_CNT, 0);
    check_output("idle_done_count", done_count, 0);
    mon_enable = 1'b1;

    // Basic frame at 1 MHz.
    done_before = done_count;
    apply_stimulus(16'h0005, 16'h8000, 32, 500, 1'b1);
    exp_frames++;
    check_output("frame1_done_pulses", done_count - done_before, 1);
    check_output("frame1_cnt", O_FRAME_CNT, exp_frames % 256);
    check_output("frame1_tail_data", O_JOY_DATA, 1);

    // Abort mid-frame with LOAD falling together with a link clock rise.
    done_before = done_count;
    apply_stimulus(16'h00F1, 16'h0F0F, 5, 500, 1'b1);
    I_JOY_CLK = 1'b0;
    #500;
    sb_queue.push_back('{do_check: 1'b0, exp_bit: 1'b1, idx: -1});
    I_JOY_LOAD = 1'b0;
    I_JOY_CLK  = 1'b1;
    #500;
    for (int i = 0; i < 10; i++) begin
      link_pulse(500, 1'b1, chain_bit(16'h00F1, 16'h0F0F, 0), 0);
    end
    I_JOY_LOAD = 1'b1;
    #500;
    check_output("abort_no_done", done_count - done_before, 0);
    check_output("abort_cnt_hold", O_FRAME_CNT, exp_frames % 256);
    shift_bits(16'h00F1, 16'h0F0F, 0, 32, 500, 1'b1);
    exp_frames++;
    check_output("after_abort_done", done_count - done_before, 1);
    check_output("after_abort_cnt", O_FRAME_CNT, exp_frames % 256);

    // Buttons change during shifting: snapshot holds until next load.
    load_snapshot(16'h0000, 16'h1234, 100, 100);
    shift_bits(16'h0000, 16'h1234, 0, 4, 80, 1'b1);
    I_JOY1 = 16'hFFFF;
    shift_bits(16'h0000, 16'h1234, 4, 28, 80, 1'b1);
    exp_frames++;
    apply_stimulus(16'hFFFF, 16'h1234, 32, 80, 1'b1);
    exp_frames++;
    check_output("snapshot_cnt", O_FRAME_CNT, exp_frames % 256);

    // Overrun: 40 link clocks after one load.
    done_before = done_count;
    apply_stimulus(16'hA5A5, 16'h5A5A, 40, 80, 1'b1);
    exp_frames++;
    check_output("overrun_single_done", done_count - done_before, 1);
    check_output("overrun_cnt", O_FRAME_CNT, exp_frames % 256);

    // Run frames until the counter wraps.
    while (exp_frames < 256) begin
      apply_stimulus(16'h0000, 16'h0000, 32, 80, 1'b0);
      exp_frames++;
    end
    check_output("wrap_cnt", O_FRAME_CNT, 0);
    check_output("wrap_total_done", done_count, 256);

    // Asynchronous reset in the middle of a frame.
    apply_stimulus(16'hFFFF, 16'hFFFF, 32, 80, 1'b0);
    exp_frames++;
    check_output("pre_reset_cnt", O_FRAME_CNT, exp_frames % 256);
    load_snapshot(16'hFFFF, 16'hFFFF, 100, 100);
    shift_bits(16'hFFFF, 16'hFFFF, 0, 10, 80, 1'b1);
    check_output("midframe_data", O_JOY_DATA, 0);
    #40;
    I_RESET_L = 1'b0;
    #1;
    check_output("async_reset_data", O_JOY_DATA, 1);
    check_output("async_reset_cnt", O_FRAME_CNT, 0);
    check_output("async_reset_done", O_FRAME_DONE, 0);
    #100;
    I_RESET_L = 1'b1;
    #100;
    exp_frames  = 0;
    done_before = done_count;
    apply_stimulus(16'h0003, 16'hC000, 32, 80, 1'b1);
    exp_frames++;
    check_output("post_reset_done", done_count - done_before, 1);
    check_output("post_reset_cnt", O_FRAME_CNT, exp_frames % 256);

    check_output("sb_queue_empty", sb_queue.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Device-side end of the DB15 serial joystick link: emulates the adapter's parallel-in/serial-out shift chain (two cascaded players) that the host-side DB15 reader drives with LOAD/CLK and samples on DATA.
- Snapshots two active-high button vectors, then presents them active-low, one bit per rising edge of the link clock.
- Used in a second core/board acting as a virtual adapter, and as a synthesizable loopback partner for reader regression.
- All link inputs are asynchronous to CLK.

Parameters:
- WIDTH, 16, bits per player (chain length = 2*WIDTH)
- SYNC_STAGES, 2, synchronizer flops on I_JOY_CLK/I_JOY_LOAD (min 2)

Ports:
- CLK  in  1  system clock, 40-50 MHz; must be at least 8x the link clock
- I_RESET_L  in  1  asynchronous active-low reset
- I_JOY1  in  WIDTH  player 1 buttons, active high (bit0=R,1=L,2=D,3=U,4..=fire/menu)
- I_JOY2  in  WIDTH  player 2 buttons, same layout
- I_JOY_LOAD  in  1  link load, active low, async
- I_JOY_CLK  in  1  link shift clock, async; advance on rising edge
- O_JOY_DATA  out  1  serial data, active low (0 = pressed)
- O_FRAME_DONE  out  1  one-CLK pulse when the last chain bit has been shifted out
- O_FRAME_CNT  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (I_RESET_L=0, async): shift register all 1s, O_JOY_DATA=1, O_FRAME_DONE=0, O_FRAME_CNT=0, bit index=0, synchronizers preset to 1 (idle-high link), state IDLE.
- Synchronizer: SYNC_STAGES flops per input, plus one history flop for edge detect.
  - Latency from pin edge to internal event: SYNC_STAGES+1 CLK.
  - O_JOY_DATA is registered and updates 1 CLK after the event.
- Chain order (index 0 first): {~I_JOY2, ~I_JOY1} bit-reversed, i.e. P1[0], P1[1] ... P1[WIDTH-1], P2[0] ... P2[WIDTH-1].
- States:
  - IDLE: holds the last value; rising CLK edges shift normally.
  - LOADING: entered while synced LOAD=0. The register is reloaded from I_JOY1/I_JOY2 every CLK (transparent, as in a 74HC165). O_JOY_DATA = ~P1[0]. Index=0. Link CLK edges are ignored.
  - SHIFT: entered when synced LOAD returns to 1. Each synced rising link-CLK edge shifts the register toward the output, shifts a 1 into the tail, and increments the index.
    - When index reaches 2*WIDTH: pulse O_FRAME_DONE, increment O_FRAME_CNT, go to IDLE. O_JOY_DATA then stays 1.
- Boundaries:
  - Link CLK rising edge in the same CLK as LOAD falling: load wins, no shift.
  - Link CLK edges beyond 2*WIDTH: shift in 1s; no further FRAME_DONE until the next load.
  - LOAD asserted mid-frame: frame aborted, no FRAME_DONE, counter unchanged, reload.
  - Button inputs changing during SHIFT: no effect until the next LOAD.
  - Async reset mid-frame: immediate return to reset values. The first post-reset LOAD starts a clean frame.
- Width rules: index is clog2(2*WIDTH)+1 bits. The counter is a plain 8-bit wrap.

Decomposition:
- Shared package joy_pkg:
  - button bit-position constants (R,L,D,U,FIRE1.., MENU)
  - typedef for the link state enum {IDLE, LOADING, SHIFT}
  - default WIDTH constant, shared with the reader
- One sub-module, joy_sync_edge: N-stage synchronizer with preset value and rising/falling pulse outputs. Instantiate it twice.

Test Plan:
- Reset release, link idle high, I_JOY1=16'h0001 -> O_JOY_DATA=1, O_FRAME_CNT=0, no FRAME_DONE.
- I_JOY1=16'h0005, I_JOY2=16'h8000. LOAD low 1 us then high, then 32 link clocks at 1 MHz.
  - Sampled DATA (before each edge) = 0,1,0, then 1 x28, then 0 at index 31.
  - FRAME_DONE pulses once; CNT=1.
- LOAD low, 10 clocks, LOAD high -> abort.
  - LOAD low coincident with a CLK rise: first bit is still P1[0], no shift.
  - CNT unchanged; a full frame afterwards returns correct data.
- Change I_JOY1 from 0 to 16'hFFFF after bit 3 of a frame -> remaining P1 bits still 1 (unpressed snapshot); the next frame shows all 0.
- 40 link clocks after one load -> bits 32..39 read 1; exactly one FRAME_DONE.
- 256 complete frames -> CNT wraps to 0.
- Drop I_RESET_L mid-frame -> outputs reset within the same cycle, asynchronously.
